// File: rtl/ysyx_23060236_scoreboard_pkg.sv
// Shared sizing constants for the register-file scoreboard.
// Sizes: 16 registers, 2-bit pending-write counters, 32-bit stall counter.
package ysyx_23060236_scoreboard_pkg;

  localparam int SB_ADDR_WIDTH = 4;
  localparam int SB_CNT_WIDTH  = 2;
  localparam int SB_PERF_WIDTH = 32;

endpackage

// File: rtl/ysyx_23060236_sb_counter.sv
// Pending-write counter for one architectural register.
// Clearing beats increment and decrement.
module ysyx_23060236_sb_counter #(
  parameter int CNT_WIDTH = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 inc,
  input  logic                 dec,
  input  logic                 clr,
  output logic [CNT_WIDTH-1:0] cnt,
  output logic                 nonzero
);

  // An increment and a decrement in the same cycle cancel out.
  always_ff @(posedge clock) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (inc && !dec) begin
      cnt <= cnt + 1'b1;
    end else if (dec && !inc) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign nonzero = |cnt;

endmodule

// File: rtl/ysyx_23060236_scoreboard.sv
// Issue-side hazard controller: tracks outstanding writebacks per register
// and stalls the decoder on RAW hazards or pending-write counter saturation.
module ysyx_23060236_scoreboard
  import ysyx_23060236_scoreboard_pkg::*;
#(
  parameter int ADDR_WIDTH = SB_ADDR_WIDTH,
  parameter int CNT_WIDTH  = SB_CNT_WIDTH
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       issue_valid,
  output logic                       issue_ready,
  input  logic [ADDR_WIDTH-1:0]      rs1,
  input  logic [ADDR_WIDTH-1:0]      rs2,
  input  logic                       rs1_used,
  input  logic                       rs2_used,
  input  logic [ADDR_WIDTH-1:0]      rd,
  input  logic                       rd_wen,
  input  logic                       wb_valid,
  input  logic [ADDR_WIDTH-1:0]      wb_addr,
  input  logic                       flush,
  output logic [2**ADDR_WIDTH-1:0]   busy_mask,
  output logic                       idle,
  output logic                       err,
  output logic [SB_PERF_WIDTH-1:0]   stall_cycles
);

  localparam int NREG = 2**ADDR_WIDTH;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [CNT_WIDTH-1:0]     cnt [NREG];
  logic [NREG-1:0]          busy;
  logic [NREG-1:1]          inc;
  logic [NREG-1:1]          dec;
  logic                     hazard;
  logic                     fire;
  logic                     wb_to_empty;
  logic [SB_PERF_WIDTH-1:0] stall_q;

  // x0 is hardwired: never pending, so it can never cause a hazard.
  assign cnt[0]  = '0;
  assign busy[0] = 1'b0;

  always_comb begin
    hazard = 1'b0;
    if (rs1_used && rs1 != '0 && busy[rs1]) hazard = 1'b1;
    if (rs2_used && rs2 != '0 && busy[rs2]) hazard = 1'b1;
    if (rd_wen && rd != '0 && cnt[rd] == CNT_MAX) hazard = 1'b1;
  end

  assign issue_ready = !reset && !flush && !hazard;
  assign fire        = issue_valid && issue_ready;

  always_comb begin
    inc = '0;
    dec = '0;
    for (int i = 1; i < NREG; i++) begin
      inc[i] = fire && rd_wen && (rd == ADDR_WIDTH'(i));
      dec[i] = wb_valid && (wb_addr == ADDR_WIDTH'(i)) && busy[i];
    end
  end

  for (genvar i = 1; i < NREG; i++) begin : g_cnt
    ysyx_23060236_sb_counter #(
      .CNT_WIDTH(CNT_WIDTH)
    ) u_cnt (
      .clock  (clock),
      .reset  (reset),
      .inc    (inc[i]),
      .dec    (dec[i]),
      .clr    (flush),
      .cnt    (cnt[i]),
      .nonzero(busy[i])
    );
  end

  // A writeback with nothing outstanding means the pipeline lost track of a register.
  assign wb_to_empty = wb_valid && wb_addr != '0 && !busy[wb_addr];

  always_ff @(posedge clock) begin
    if (reset) begin
      err <= 1'b0;
    end else if (!flush && wb_to_empty) begin
      err <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_q <= '0;
    end else if (issue_valid && !issue_ready && stall_q != '1) begin
      stall_q <= stall_q + 1'b1;
    end
  end

  assign busy_mask    = busy;
  assign idle         = ~|busy;
  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_ysyx_23060236_scoreboard.sv
// Directed self-checking bench for the register-file scoreboard.
module tb_ysyx_23060236_scoreboard;

  logic        clock;
  logic        reset;
  logic        issue_valid;
  logic        issue_ready;
  logic [3:0]  rs1;
  logic [3:0]  rs2;
  logic        rs1_used;
  logic        rs2_used;
  logic [3:0]  rd;
  logic        rd_wen;
  logic        wb_valid;
  logic [3:0]  wb_addr;
  logic        flush;
  logic [15:0] busy_mask;
  logic        idle;
  logic        err;
  logic [31:0] stall_cycles;

  int compared;
  int mismatched;

  ysyx_23060236_scoreboard dut (
    .clock       (clock),
    .reset       (reset),
    .issue_valid (issue_valid),
    .issue_ready (issue_ready),
    .rs1         (rs1),
    .rs2         (rs2),
    .rs1_used    (rs1_used),
    .rs2_used    (rs2_used),
    .rd          (rd),
    .rd_wen      (rd_wen),
    .wb_valid    (wb_valid),
    .wb_addr     (wb_addr),
    .flush       (flush),
    .busy_mask   (busy_mask),
    .idle        (idle),
    .err         (err),
    .stall_cycles(stall_cycles)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Inputs change just after the falling edge; checks run 1ns later.
  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic drive(input logic iv, input logic [3:0] s1, input logic u1,
                       input logic [3:0] s2, input logic u2, input logic [3:0] d,
                       input logic w, input logic wbv, input logic [3:0] wba,
                       input logic fl);
    issue_valid = iv;
    rs1 = s1; rs1_used = u1;
    rs2 = s2; rs2_used = u2;
    rd = d; rd_wen = w;
    wb_valid = wbv; wb_addr = wba;
    flush = fl;
    #1;
  endtask

  task automatic idle_inputs();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1, 4'd2, 1, 0, 0, 4'd6, 1, 1, 4'd6, 0);
    compared++;
    if (issue_ready !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_ready: got %b want 0", issue_ready);
    end
    tick();
    compared++;
    if (busy_mask !== 16'h0000 || idle !== 1'b1 || err !== 1'b0 || stall_cycles !== 32'd0) begin
      mismatched++;
      $display("[TB] FAIL reset_state: busy=%h idle=%b err=%b stall=%0d want 0000/1/0/0",
               busy_mask, idle, err, stall_cycles);
    end
    reset = 1'b0;
    idle_inputs();
    tick();
  endtask

  task automatic test_raw();
    drive(1, 0, 0, 0, 0, 4'd5, 1, 0, 0, 0);
    compared++;
    if (issue_ready !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL raw_issue_rd5: ready=%b want 1", issue_ready);
    end
    tick();
    drive(1, 4'd5, 1, 0, 0, 0, 0, 0, 0, 0);
    compared++;
    if (busy_mask !== 16'h0020 || idle !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL raw_busy5: busy=%h idle=%b want 0020/0", busy_mask, idle);
    end
    compared++;
    if (issue_ready !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL raw_stall: ready=%b want 0", issue_ready);
    end
    tick();
    compared++;
    if (stall_cycles !== 32'd1) begin
      mismatched++;
      $display("[TB] FAIL raw_stall_cnt1: got %0d want 1", stall_cycles);
    end
    tick();
    compared++;
    if (stall_cycles !== 32'd2) begin
      mismatched++;
      $display("[TB] FAIL raw_stall_cnt2: got %0d want 2", stall_cycles);
    end
    drive(1, 4'd5, 1, 0, 0, 0, 0, 1, 4'd5, 0);
    compared++;
    if (issue_ready !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL raw_no_bypass: ready=%b want 0", issue_ready);
    end
    tick();
    drive(1, 4'd5, 1, 0, 0, 0, 0, 0, 0, 0);
    compared++;
    if (busy_mask !== 16'h0000 || issue_ready !== 1'b1 || stall_cycles !== 32'd3) begin
      mismatched++;
      $display("[TB] FAIL raw_release: busy=%h ready=%b stall=%0d want 0000/1/3",
               busy_mask, issue_ready, stall_cycles);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_saturation();
    for (int k = 0; k < 3; k++) begin
      drive(1, 0, 0, 0, 0, 4'd3, 1, 0, 0, 0);
      compared++;
      if (issue_ready !== 1'b1) begin
        mismatched++;
        $display("[TB] FAIL sat_fill%0d: ready=%b want 1", k, issue_ready);
      end
      tick();
    end
    drive(1, 0, 0, 0, 0, 4'd3, 1, 0, 0, 0);
    compared++;
    if (issue_ready !== 1'b0 || busy_mask !== 16'h0008) begin
      mismatched++;
      $display("[TB] FAIL sat_full: ready=%b busy=%h want 0/0008", issue_ready, busy_mask);
    end
    tick();
    drive(1, 0, 0, 0, 0, 4'd3, 1, 1, 4'd3, 0);
    compared++;
    if (issue_ready !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL sat_wb_cycle: ready=%b want 0", issue_ready);
    end
    tick();
    drive(1, 0, 0, 0, 0, 4'd3, 1, 0, 0, 0);
    compared++;
    if (issue_ready !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL sat_after_dec: ready=%b want 1", issue_ready);
    end
    tick();
    compared++;
    if (issue_ready !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL sat_refull: ready=%b want 0", issue_ready);
    end
    // Drop to 2, then issue and write back x3 together: count must stay at 2.
    drive(0, 0, 0, 0, 0, 0, 0, 1, 4'd3, 0);
    tick();
    drive(1, 0, 0, 0, 0, 4'd3, 1, 1, 4'd3, 0);
    compared++;
    if (issue_ready !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL sat_same_cycle: ready=%b want 1", issue_ready);
    end
    tick();
    drive(1, 0, 0, 0, 0, 4'd3, 1, 0, 0, 0);
    compared++;
    if (issue_ready !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL sat_cnt_two: ready=%b want 1", issue_ready);
    end
    tick();
    compared++;
    if (issue_ready !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL sat_cnt_three: ready=%b want 0", issue_ready);
    end
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 1, 4'd3, 0);
      tick();
    end
    idle_inputs();
    compared++;
    if (busy_mask !== 16'h0000 || idle !== 1'b1 || err !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL sat_drain: busy=%h idle=%b err=%b want 0000/1/0", busy_mask, idle, err);
    end
  endtask

  task automatic test_x0();
    for (int k = 0; k < 3; k++) begin
      drive(1, 4'd0, 1, 4'd0, 1, 4'd0, 1, 1, 4'd0, 0);
      compared++;
      if (issue_ready !== 1'b1) begin
        mismatched++;
        $display("[TB] FAIL x0_ready%0d: ready=%b want 1", k, issue_ready);
      end
      tick();
    end
    idle_inputs();
    compared++;
    if (busy_mask !== 16'h0000 || err !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL x0_state: busy=%h err=%b want 0000/0", busy_mask, err);
    end
  endtask

  task automatic test_flush();
    drive(1, 0, 0, 0, 0, 4'd1, 1, 0, 0, 0); tick();
    drive(1, 0, 0, 0, 0, 4'd2, 1, 0, 0, 0); tick();
    drive(1, 0, 0, 0, 0, 4'd9, 1, 0, 0, 0); tick();
    drive(1, 0, 0, 0, 0, 4'd4, 1, 1, 4'd1, 1);
    compared++;
    if (busy_mask !== 16'h0206 || issue_ready !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL flush_cycle: busy=%h ready=%b want 0206/0", busy_mask, issue_ready);
    end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 1, 4'd6, 1);
    compared++;
    if (busy_mask !== 16'h0000 || idle !== 1'b1 || err !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL flush_after: busy=%h idle=%b err=%b want 0000/1/0", busy_mask, idle, err);
    end
    tick();
    idle_inputs();
    compared++;
    if (err !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL flush_no_err: err=%b want 0", err);
    end
  endtask

  task automatic test_err();
    drive(0, 0, 0, 0, 0, 0, 0, 1, 4'd7, 0);
    tick();
    idle_inputs();
    compared++;
    if (err !== 1'b1 || busy_mask !== 16'h0000) begin
      mismatched++;
      $display("[TB] FAIL err_set: err=%b busy=%h want 1/0000", err, busy_mask);
    end
    tick();
    tick();
    compared++;
    if (err !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL err_sticky: err=%b want 1", err);
    end
  endtask

  task automatic test_stall_saturate_and_reset();
    drive(1, 0, 0, 0, 0, 4'd8, 1, 0, 0, 0);
    tick();
    drive(1, 4'd8, 1, 0, 0, 0, 0, 0, 0, 0);
    force dut.stall_q = 32'hFFFF_FFFD;
    #1;
    release dut.stall_q;
    tick();
    compared++;
    if (stall_cycles !== 32'hFFFF_FFFE) begin
      mismatched++;
      $display("[TB] FAIL stall_near_max: got %h want fffffffe", stall_cycles);
    end
    tick();
    tick();
    compared++;
    if (stall_cycles !== 32'hFFFF_FFFF) begin
      mismatched++;
      $display("[TB] FAIL stall_hold_max: got %h want ffffffff", stall_cycles);
    end
    reset = 1'b1;
    drive(1, 4'd8, 1, 0, 0, 4'd8, 1, 1, 4'd8, 0);
    tick();
    compared++;
    if (stall_cycles !== 32'd0 || busy_mask !== 16'h0000 || idle !== 1'b1 || err !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL midstream_reset: stall=%h busy=%h idle=%b err=%b want 0/0000/1/0",
               stall_cycles, busy_mask, idle, err);
    end
    reset = 1'b0;
    drive(1, 4'd8, 1, 0, 0, 4'd8, 1, 0, 0, 0);
    compared++;
    if (issue_ready !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL post_reset_issue: ready=%b want 1", issue_ready);
    end
    tick();
    idle_inputs();
  endtask

  initial begin
    compared = 0;
    mismatched = 0;
    reset = 1'b1;
    idle_inputs();
    tick();
    tick();
    test_reset();
    test_raw();
    test_saturation();
    test_x0();
    test_flush();
    test_err();
    test_stall_saturate_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
